// File: rtl/mure_row_scheduler.sv
// Walks the heads of the lockstep commit-port FIFOs one slot per cycle, presents each
// present slot to the block-building FSM, and issues one pop per consumed or flushed row.
module mure_row_scheduler #(
  parameter int NRET      = 2,
  parameter int ITYPE_LEN = 2,
  parameter int CNT_W     = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NRET-1:0]                    empty_i,
  input  logic [NRET-1:0]                    valid_i,
  input  logic [NRET-1:0][ITYPE_LEN-1:0]     itype_i,
  input  logic                               ready_i,
  input  logic                               flush_i,
  output logic [$clog2(NRET)-1:0]            sel_o,
  output logic                               valid_o,
  output logic                               last_o,
  output logic                               pop_o,
  output logic                               busy_o,
  output logic [CNT_W-1:0]                   trunc_cnt_o
);

  // state | meaning
  // IDLE  | FIFOs empty, nothing presented
  // SCAN  | walking slots of the head row
  typedef enum logic {IDLE, SCAN} state_e;

  localparam int SEL_W = $clog2(NRET);
  localparam logic [SEL_W-1:0]     LAST_IDX = SEL_W'(NRET - 1);
  localparam logic [ITYPE_LEN-1:0] IT_EXC   = ITYPE_LEN'(1);
  localparam logic [ITYPE_LEN-1:0] IT_IRQ   = ITYPE_LEN'(2);

  state_e             state_q;
  logic [SEL_W-1:0]   idx_q;
  logic [ITYPE_LEN-1:0] head_itype;
  logic               special;
  logic               present;
  logic               at_last;
  logic               active;
  logic               accept;
  logic               skip;

  // FIFOs are pushed in lockstep, so only port 0 decides emptiness.
  logic unused_empty;
  assign unused_empty = ^empty_i[NRET-1:1];

  assign head_itype = itype_i[idx_q];
  assign special    = (head_itype == IT_EXC) || (head_itype == IT_IRQ);
  assign present    = valid_i[idx_q] || special;
  assign at_last    = (idx_q == LAST_IDX);
  assign active     = (state_q == SCAN) && !empty_i[0];

  assign sel_o  = idx_q;
  assign busy_o = (state_q == SCAN);

  always_comb begin
    valid_o = active && !flush_i && present;
    last_o  = valid_o && (special || at_last);
    accept  = valid_o && ready_i;
    skip    = active && !flush_i && !present;
    pop_o   = (active && flush_i) || (accept && last_o) || (skip && at_last);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      trunc_cnt_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          idx_q <= '0;
          if (!empty_i[0]) state_q <= SCAN;
        end
        SCAN: begin
          if (empty_i[0]) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else if (pop_o) begin
            idx_q <= '0;
          end else if (accept || skip) begin
            idx_q <= idx_q + SEL_W'(1);
          end
          // Only an early cut counts; a special entry in the final slot ends the row anyway.
          if (accept && special && !at_last && (trunc_cnt_o != '1))
            trunc_cnt_o <= trunc_cnt_o + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
